// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - glyph constants and scan FSM state type shared by segment logic
package seg_pkg;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  // Entry i is the active-high pattern for hex digit i.
  localparam logic [15:0][6:0] GLYPHS = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } seg_state_e;

endpackage

// File: rtl/seg2hex.sv
// rtl/seg2hex.sv - combinational active-high 7-segment pattern to hex decoder
module seg2hex
  import seg_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] val,
  output logic       err
);

  always_comb begin
    val = 4'h0;
    err = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (pat == GLYPHS[i]) begin
        val = 4'(i);
        err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_reader.sv
// rtl/seg_scan_reader.sv - captures debounced digits from a multiplexed 7-segment scan
// Optional illegal-capture counter output err_cnt enabled by SEG_SCAN_ERR_CNT_EN.
module seg_scan_reader
  import seg_pkg::*;
#(
  parameter int STABLE_CYC = 4,
  parameter int NUM_DIG    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           seg_n,
  input  logic [NUM_DIG-1:0]   an_n,
  output logic                 digit_vld,
  output logic [1:0]           digit_idx,
  output logic [3:0]           digit_val,
  output logic                 digit_err,
  output logic [4*NUM_DIG-1:0] disp_hex,
  output logic                 frame_vld
`ifdef SEG_SCAN_ERR_CNT_EN
  ,
  output logic [7:0]           err_cnt
`endif
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  seg_state_e state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [6:0]           seg_q, seg_prev_q;
  logic [NUM_DIG-1:0]   an_q, an_prev_q;
  logic [NUM_DIG-1:0]   frame_q;
  logic                 vld_q, err_q, frame_vld_q;
  logic [1:0]           idx_q;
  logic [3:0]           val_q;
  logic [4*NUM_DIG-1:0] disp_q;

  logic                 an_onehot, same, capture;
  logic [1:0]           an_idx;
  logic [3:0]           dec_val;
  logic                 dec_err;
  logic [NUM_DIG-1:0]   frame_set;

  assign an_onehot = $onehot(~an_q);
  assign same      = (seg_q == seg_prev_q) && (an_q == an_prev_q);
  assign frame_set = frame_q | (NUM_DIG'(1) << an_idx);

  always_comb begin
    an_idx = 2'd0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (!an_q[i]) an_idx = 2'(i);
    end
  end

  seg2hex u_seg2hex (
    .pat (~seg_q),
    .val (dec_val),
    .err (dec_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (an_onehot) begin
          state_d = SETTLE;
          cnt_d   = CNT_ONE;
        end
      end
      SETTLE: begin
        if (!same) begin
          if (an_onehot) begin
            cnt_d = CNT_ONE;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
          if (cnt_d == CNT_MAX) begin
            state_d = HOLD;
            capture = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!same) begin
          if (an_onehot) begin
            state_d = SETTLE;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      seg_q      <= '1;
      an_q       <= '1;
      seg_prev_q <= '1;
      an_prev_q  <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seg_q      <= seg_n;
      an_q       <= an_n;
      seg_prev_q <= seg_q;
      an_prev_q  <= an_q;
    end
  end

  // Capture outputs hold their last values between pulses; only vld/frame_vld pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= 1'b0;
      idx_q       <= 2'd0;
      val_q       <= 4'h0;
      err_q       <= 1'b0;
      disp_q      <= '0;
      frame_q     <= '0;
      frame_vld_q <= 1'b0;
    end else begin
      vld_q       <= capture;
      frame_vld_q <= capture && (&frame_set);
      if (capture) begin
        idx_q <= an_idx;
        val_q <= dec_val;
        err_q <= dec_err;
        if (!dec_err) disp_q[4*an_idx +: 4] <= dec_val;
        frame_q <= (&frame_set) ? '0 : frame_set;
      end
    end
  end

`ifdef SEG_SCAN_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else if (capture && dec_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign digit_vld = vld_q;
  assign digit_idx = idx_q;
  assign digit_val = val_q;
  assign digit_err = err_q;
  assign disp_hex  = disp_q;
  assign frame_vld = frame_vld_q;

endmodule

// File: tb/tb_seg_scan_reader.sv
// tb/tb_seg_scan_reader.sv - bench for seg_scan_reader against a sample-run reference model
module tb_seg_scan_reader;

  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        digit_vld;
  logic [1:0]  digit_idx;
  logic [3:0]  digit_val;
  logic        digit_err;
  logic [15:0] disp_hex;
  logic        frame_vld;
`ifdef SEG_SCAN_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  seg_scan_reader #(.STABLE_CYC(SC), .NUM_DIG(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_n     (seg_n),
    .an_n      (an_n),
    .digit_vld (digit_vld),
    .digit_idx (digit_idx),
    .digit_val (digit_val),
    .digit_err (digit_err),
    .disp_hex  (disp_hex),
    .frame_vld (frame_vld)
`ifdef SEG_SCAN_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [6:0] GLY [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_vec = 0;
  int n_err = 0;

  // Model: a capture fires when a run of identical one-hot samples reaches SC,
  // and becomes visible one cycle after the sample that completes the run.
  logic [6:0]  m_seg;
  logic [3:0]  m_an;
  bit          m_have;
  int          m_run;
  bit          p_vld, p_frame, p_err;
  logic [1:0]  p_idx;
  logic [3:0]  p_val;
  logic [15:0] e_disp;
  logic [3:0]  e_mask;
  int          e_errcnt;

  int          kind, len;
  logic [6:0]  rs;
  logic [3:0]  ra;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_decode(input logic [6:0] pat, output logic [3:0] v, output bit e);
    v = 4'h0;
    e = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (GLY[k] == pat) begin
        v = 4'(k);
        e = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_have   = 1'b0;
    m_run    = 0;
    m_seg    = '1;
    m_an     = '1;
    p_vld    = 1'b0;
    p_frame  = 1'b0;
    p_err    = 1'b0;
    p_idx    = 2'd0;
    p_val    = 4'h0;
    e_disp   = 16'h0;
    e_mask   = 4'h0;
    e_errcnt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".digit_vld"}, 32'(digit_vld), 32'd0);
    check({tag, ".digit_idx"}, 32'(digit_idx), 32'd0);
    check({tag, ".digit_val"}, 32'(digit_val), 32'd0);
    check({tag, ".digit_err"}, 32'(digit_err), 32'd0);
    check({tag, ".disp_hex"},  32'(disp_hex),  32'd0);
    check({tag, ".frame_vld"}, 32'(frame_vld), 32'd0);
`ifdef SEG_SCAN_ERR_CNT_EN
    check({tag, ".err_cnt"},   32'(err_cnt),   32'd0);
`endif
  endtask

  task automatic step(input logic [6:0] s, input logic [3:0] a);
    seg_n = s;
    an_n  = a;
    @(posedge clk);
    #1;
    if (p_vld && !p_err) e_disp[4*p_idx +: 4] = p_val;
    if (p_vld && p_err && e_errcnt < 255) e_errcnt++;
    check("digit_vld", 32'(digit_vld), 32'(p_vld));
    if (p_vld) begin
      check("digit_idx", 32'(digit_idx), 32'(p_idx));
      check("digit_val", 32'(digit_val), 32'(p_val));
      check("digit_err", 32'(digit_err), 32'(p_err));
    end
    check("frame_vld", 32'(frame_vld), 32'(p_frame));
    check("disp_hex", 32'(disp_hex), 32'(e_disp));
`ifdef SEG_SCAN_ERR_CNT_EN
    check("err_cnt", 32'(err_cnt), 32'(e_errcnt));
`endif
    if (m_have && s == m_seg && a == m_an) m_run++;
    else m_run = 1;
    m_have  = 1'b1;
    m_seg   = s;
    m_an    = a;
    p_vld   = ($countones(~a) == 1) && (m_run == SC);
    p_frame = 1'b0;
    if (p_vld) begin
      for (int k = 0; k < 4; k++) if (!a[k]) p_idx = 2'(k);
      ref_decode(~s, p_val, p_err);
      e_mask = e_mask | (4'd1 << p_idx);
      if (&e_mask) begin
        p_frame = 1'b1;
        e_mask  = 4'h0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(7'h7F, 4'hF);
  endtask

  initial begin
    rst_n = 1'b0;
    seg_n = 7'h7F;
    an_n  = 4'hF;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    // Stable 8 on position 0.
    repeat (6) step(~7'h7F, 4'b1110);
    idle(2);
    check("disp0_is_8", 32'(disp_hex[3:0]), 32'h8);

    // Short run of 3 then a different glyph for 4 on position 1.
    repeat (3) step(~GLY[5], 4'b1101);
    repeat (4) step(~GLY[6], 4'b1101);
    idle(2);
    check("disp1_is_6", 32'(disp_hex[7:4]), 32'h6);

    // Illegal pattern on position 2.
    repeat (5) step(~7'h7E, 4'b1011);
    idle(2);
`ifdef SEG_SCAN_ERR_CNT_EN
    check("err_cnt_one", 32'(err_cnt), 32'd1);
`endif

    // Full scan 1,2,3,4 across positions 0..3.
    for (int d = 0; d < 4; d++) repeat (5) step(~GLY[d+1], ~(4'd1 << d));
    idle(2);
    check("scan_disp", 32'(disp_hex), 32'h4321);

    // Multi-hot and all-high strobes never capture.
    repeat (10) step(~GLY[2], 4'b1100);
    repeat (5) step(~GLY[3], 4'b0000);
    idle(2);

    // Reset asserted after three stable counts: no pulse, fresh run needed.
    repeat (4) step(~GLY[9], 4'b0111);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midreset");
    model_reset();
    rst_n = 1'b1;
    repeat (6) step(~GLY[9], 4'b0111);
    idle(2);

    for (int r = 0; r < 80; r++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 7);
      ra   = ~(4'd1 << $urandom_range(0, 3));
      rs   = ~GLY[$urandom_range(0, 15)];
      if (kind >= 6 && kind < 8) rs = 7'($urandom);
      else if (kind >= 8) ra = 4'($urandom);
      repeat (len) step(rs, ra);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
